// File: rtl/upsample_pkg.sv
// Shared types and width helpers for the upsample stream block.
package upsample_pkg;

  typedef enum logic {
    UPS_NEAREST = 1'b0,
    UPS_LINEAR  = 1'b1
  } ups_mode_e;

  typedef enum logic [1:0] {
    UPS_IDLE   = 2'd0,
    UPS_PREP   = 2'd1,
    UPS_STREAM = 2'd2,
    UPS_DONE   = 2'd3
  } ups_state_e;

  // Counter/port width for a range of n values, never narrower than one bit.
  function automatic int ups_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit ups_is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/upsample_interp_unit.sv
// Combinational sample generator: repeat x0, or step linearly from x0 toward x1
// by j/SCALE_FACTOR with floor rounding.
module upsample_interp_unit
  import upsample_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int SCALE_FACTOR = 2
) (
  input  logic signed [DATA_WIDTH-1:0]            x0,
  input  logic signed [DATA_WIDTH-1:0]            x1,
  input  logic        [$clog2(SCALE_FACTOR)-1:0]  j,
  input  ups_mode_e                               mode,
  output logic signed [DATA_WIDTH-1:0]            sample
);

  localparam int LOG2S = $clog2(SCALE_FACTOR);
  localparam int PW    = DATA_WIDTH + LOG2S + 2;

  logic signed [DATA_WIDTH:0] diff;
  logic signed [PW-1:0]       prod;
  logic signed [PW-1:0]       step;
  logic                       unused_step_hi;

  always_comb begin
    diff = {x1[DATA_WIDTH-1], x1} - {x0[DATA_WIDTH-1], x0};
    prod = PW'(diff) * PW'($signed({1'b0, j}));
    step = prod >>> LOG2S;
    // |step| never exceeds |x1-x0|, so the low DATA_WIDTH bits carry the full result.
    if (mode == UPS_LINEAR) begin
      sample = x0 + step[DATA_WIDTH-1:0];
    end else begin
      sample = x0;
    end
  end

  assign unused_step_hi = ^step[PW-1:DATA_WIDTH];

endmodule

// File: rtl/upsample_stream.sv
// Captures a multi-channel frame block and streams it out upsampled by
// SCALE_FACTOR, channel-major, under a valid/ready handshake.
module upsample_stream
  import upsample_pkg::*;
#(
  parameter int NUM_CHANNELS = 2,
  parameter int FRAMES_IN    = 2,
  parameter int SCALE_FACTOR = 2,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic                                                      i_start,
  input  logic                                                      i_mode,
  input  logic signed [NUM_CHANNELS-1:0][FRAMES_IN-1:0][DATA_WIDTH-1:0] i_data,
  input  logic                                                      i_ready,
  output logic                                                      o_valid,
  output logic signed [DATA_WIDTH-1:0]                              o_data,
  output logic [ups_width(NUM_CHANNELS)-1:0]                        o_ch,
  output logic [ups_width(FRAMES_IN*SCALE_FACTOR)-1:0]              o_idx,
  output logic                                                      o_busy,
  output logic                                                      o_done_tick
);

  localparam int OUT_FRAMES = FRAMES_IN * SCALE_FACTOR;
  localparam int CW         = ups_width(NUM_CHANNELS);
  localparam int IW         = ups_width(OUT_FRAMES);
  localparam int KW         = ups_width(FRAMES_IN);
  localparam int LOG2S      = $clog2(SCALE_FACTOR);

  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CHANNELS - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(OUT_FRAMES - 1);
  localparam logic [KW-1:0] LAST_K   = KW'(FRAMES_IN - 1);

  if (!ups_is_pow2(SCALE_FACTOR) || (SCALE_FACTOR < 2)) begin : g_bad_scale
    $error("upsample_stream: SCALE_FACTOR must be a power of 2 and at least 2");
  end

  ups_state_e state;
  ups_mode_e  mode_q;
  logic signed [NUM_CHANNELS-1:0][FRAMES_IN-1:0][DATA_WIDTH-1:0] data_q;

  logic                         last;
  logic [CW-1:0]                nxt_ch;
  logic [IW-1:0]                nxt_idx;
  logic [KW-1:0]                k;
  logic [KW-1:0]                k1;
  logic [LOG2S-1:0]             j;
  logic signed [DATA_WIDTH-1:0] x0;
  logic signed [DATA_WIDTH-1:0] x1;
  logic signed [DATA_WIDTH-1:0] sample;

  // Coordinates of the sample to be loaded next: (0,0) from PREP, else the successor.
  always_comb begin
    last    = (o_ch == LAST_CH) && (o_idx == LAST_IDX);
    nxt_ch  = o_ch;
    nxt_idx = o_idx + IW'(1);
    if (state == UPS_PREP) begin
      nxt_ch  = '0;
      nxt_idx = '0;
    end else if (o_idx == LAST_IDX) begin
      nxt_ch  = o_ch + CW'(1);
      nxt_idx = '0;
    end
  end

  // The last input frame has no right neighbour, so it is paired with itself.
  always_comb begin
    k  = KW'(nxt_idx >> LOG2S);
    j  = nxt_idx[LOG2S-1:0];
    k1 = (k == LAST_K) ? k : k + KW'(1);
    x0 = data_q[nxt_ch][k];
    x1 = data_q[nxt_ch][k1];
  end

  upsample_interp_unit #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SCALE_FACTOR(SCALE_FACTOR)
  ) u_interp (
    .x0    (x0),
    .x1    (x1),
    .j     (j),
    .mode  (mode_q),
    .sample(sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= UPS_IDLE;
      mode_q      <= UPS_NEAREST;
      data_q      <= '0;
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_ch        <= '0;
      o_idx       <= '0;
      o_done_tick <= 1'b0;
    end else begin
      o_done_tick <= 1'b0;
      case (state)
        UPS_IDLE: begin
          if (i_start) begin
            data_q <= i_data;
            mode_q <= ups_mode_e'(i_mode);
            state  <= UPS_PREP;
          end
        end
        UPS_PREP: begin
          o_data  <= sample;
          o_ch    <= nxt_ch;
          o_idx   <= nxt_idx;
          o_valid <= 1'b1;
          state   <= UPS_STREAM;
        end
        UPS_STREAM: begin
          if (o_valid && i_ready) begin
            if (last) begin
              o_valid     <= 1'b0;
              o_data      <= '0;
              o_ch        <= '0;
              o_idx       <= '0;
              o_done_tick <= 1'b1;
              state       <= UPS_DONE;
            end else begin
              o_data <= sample;
              o_ch   <= nxt_ch;
              o_idx  <= nxt_idx;
            end
          end
        end
        UPS_DONE: begin
          state <= UPS_IDLE;
        end
        default: begin
          state <= UPS_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state != UPS_IDLE);

endmodule

// File: tb/tb_upsample_stream.sv
// Bench for upsample_stream: directed and randomized jobs against an
// arithmetic reference model, plus a linear S=4 single-channel instance.
module tb_upsample_stream;

  localparam int PER_CH = 4;
  localparam int TOTAL  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic start_a = 1'b0, mode_a = 1'b0, ready_a = 1'b0;
  logic signed [1:0][1:0][15:0] data_a = '0;
  logic valid_a, busy_a, tick_a;
  logic signed [15:0] odata_a;
  logic [0:0] och_a;
  logic [1:0] oidx_a;

  logic start_b = 1'b0, mode_b = 1'b0, ready_b = 1'b0;
  logic signed [0:0][1:0][15:0] data_b = '0;
  logic valid_b, busy_b, tick_b;
  logic signed [15:0] odata_b;
  logic [0:0] och_b;
  logic [2:0] oidx_b;

  upsample_stream #(.NUM_CHANNELS(2), .FRAMES_IN(2), .SCALE_FACTOR(2), .DATA_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .i_start(start_a), .i_mode(mode_a), .i_data(data_a),
    .i_ready(ready_a), .o_valid(valid_a), .o_data(odata_a), .o_ch(och_a),
    .o_idx(oidx_a), .o_busy(busy_a), .o_done_tick(tick_a));

  upsample_stream #(.NUM_CHANNELS(1), .FRAMES_IN(2), .SCALE_FACTOR(4), .DATA_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .i_start(start_b), .i_mode(mode_b), .i_data(data_b),
    .i_ready(ready_b), .o_valid(valid_b), .o_data(odata_b), .o_ch(och_b),
    .o_idx(oidx_b), .o_busy(busy_b), .o_done_tick(tick_b));

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Output n of a 2ch / 2-frame / x2 job, straight from the interpolation rule.
  function automatic int ref_sample(input int x[2][2], input bit lin, input int n);
    int c, i, k, j, d, q;
    c = n / PER_CH;
    i = n % PER_CH;
    k = i / 2;
    j = i % 2;
    if (!lin || k == 1) return x[c][k];
    d = (x[c][k+1] - x[c][k]) * j;
    q = d / 2;
    if (d < 0 && (d % 2) != 0) q = q - 1;
    return x[c][k] + q;
  endfunction

  task automatic run_job(input string tag, input int x[2][2], input bit lin,
                         input int ready_pct, input int stall_n, input bit poke);
    int n = 0, cyc = 0, stall = 0, early_ticks = 0;
    bit rdy, hs, seen = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int f = 0; f < 2; f++) data_a[c][f] = 16'(x[c][f]);
    mode_a  = lin;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int c = 0; c < 2; c++)
      for (int f = 0; f < 2; f++) data_a[c][f] = 16'($urandom);
    chk({tag, " busy_after_start"}, busy_a, 1);
    chk({tag, " valid_in_prep"}, valid_a, 0);
    while (n < TOTAL && cyc < 300) begin
      if (seen && ready_pct == 100) chk({tag, " no_bubble"}, valid_a, 1);
      if (valid_a) begin
        seen = 1'b1;
        chk({tag, " data"}, odata_a, ref_sample(x, lin, n));
        chk({tag, " ch"}, och_a, n / PER_CH);
        chk({tag, " idx"}, oidx_a, n % PER_CH);
      end
      if (tick_a) early_ticks++;
      if (n == stall_n && stall < 3) begin
        rdy = 1'b0;
        stall++;
      end else begin
        rdy = ($urandom_range(0, 99) < ready_pct);
      end
      ready_a = rdy;
      if (poke) begin
        start_a = 1'($urandom_range(0, 1));
        mode_a  = 1'($urandom_range(0, 1));
        for (int c = 0; c < 2; c++)
          for (int f = 0; f < 2; f++) data_a[c][f] = 16'($urandom);
      end
      hs = valid_a && rdy;
      @(posedge clk); #1;
      if (hs) n++;
      cyc++;
    end
    start_a = 1'b0;
    ready_a = 1'b0;
    chk({tag, " samples_within_budget"}, n, TOTAL);
    chk({tag, " no_early_tick"}, early_ticks, 0);
    chk({tag, " done_tick"}, tick_a, 1);
    chk({tag, " valid_after_last"}, valid_a, 0);
    @(posedge clk); #1;
    chk({tag, " done_tick_one_cycle"}, tick_a, 0);
    chk({tag, " idle"}, busy_a, 0);
  endtask

  initial begin
    int xa[2][2];
    int expb[8];
    int nb, cyc, ticks;

    #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("reset valid", valid_a, 0);
    chk("reset busy", busy_a, 0);
    chk("reset tick", tick_a, 0);
    chk("reset data", odata_a, 0);
    chk("reset ch", och_a, 0);
    chk("reset idx", oidx_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    xa = '{'{111, 222}, '{333, 444}};
    run_job("nearest_dir", xa, 1'b0, 100, -1, 1'b0);

    xa = '{'{-50, 60}, '{60, -80}};
    run_job("linear_dir", xa, 1'b1, 100, -1, 1'b0);

    xa = '{'{1000, -1000}, '{-7, 9}};
    run_job("stall_idx2", xa, 1'b1, 100, 2, 1'b0);

    xa = '{'{5, 17}, '{-3, 42}};
    run_job("start_ignored", xa, 1'b1, 80, -1, 1'b1);

    // Linear x4 single-channel instance: ramp then clamped edge.
    expb = '{0, 64, 128, 192, 256, 256, 256, 256};
    data_b[0][0] = 16'sd0;
    data_b[0][1] = 16'sd256;
    mode_b  = 1'b1;
    ready_b = 1'b1;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    nb = 0;
    cyc = 0;
    while (nb < 8 && cyc < 40) begin
      if (valid_b) begin
        chk("lin4 data", odata_b, expb[nb]);
        chk("lin4 idx", oidx_b, nb);
        nb++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("lin4 count", nb, 8);
    chk("lin4 done_tick", tick_b, 1);
    ready_b = 1'b0;
    @(posedge clk); #1;

    // Abort a job mid-stream with an asynchronous reset pulse.
    for (int c = 0; c < 2; c++)
      for (int f = 0; f < 2; f++) data_a[c][f] = 16'(c * 10 + f + 1);
    mode_a  = 1'b0;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort valid", valid_a, 0);
    chk("abort busy", busy_a, 0);
    chk("abort data", odata_a, 0);
    chk("abort ch", och_a, 0);
    chk("abort idx", oidx_a, 0);
    chk("abort tick", tick_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ticks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (tick_a) ticks++;
    end
    chk("abort no_done_tick", ticks, 0);
    ready_a = 1'b0;

    xa = '{'{-32768, 32767}, '{32767, -32768}};
    run_job("after_abort", xa, 1'b1, 100, -1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      for (int c = 0; c < 2; c++)
        for (int f = 0; f < 2; f++) xa[c][f] = int'($signed(16'($urandom)));
      run_job("random", xa, 1'($urandom_range(0, 1)),
              (t % 3 == 0) ? 100 : ((t % 3 == 1) ? 70 : 35), -1, 1'(t % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/upsample_stream.md
UPSAMPLE_STREAM -- requirements
Module: upsample_stream

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2, meaning the number of independent channels.
REQ-002 SHALL have parameter FRAMES_IN, default 2, meaning the number of input frames per channel (>=1).
REQ-003 SHALL have parameter SCALE_FACTOR, default 2, meaning the output-to-input frame ratio (power of 2, >=2).
REQ-004 SHALL have parameter DATA_WIDTH, default 16, meaning the signed sample width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port i_start, input, 1 bit: begin a job, sampled in IDLE only.
REQ-008 SHALL have port i_mode, input, 1 bit: 0 = nearest (repeat), 1 = linear interpolation; captured with i_start.
REQ-009 SHALL have port i_data, input, signed [NUM_CHANNELS][FRAMES_IN] x DATA_WIDTH: the input frames, captured with i_start.
REQ-010 SHALL have port i_ready, input, 1 bit: downstream accepts o_data.
REQ-011 SHALL have port o_valid, output, 1 bit: o_data, o_ch and o_idx are valid.
REQ-012 SHALL have port o_data, output, signed DATA_WIDTH: the current output sample.
REQ-013 SHALL have port o_ch, output, clog2(NUM_CHANNELS) bits (min 1): channel of o_data.
REQ-014 SHALL have port o_idx, output, clog2(FRAMES_IN*SCALE_FACTOR) bits: output frame index.
REQ-015 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port o_done_tick, output, 1 bit: one-cycle pulse on job completion.

Function
REQ-017 SHALL implement FSM states IDLE, PREP, STREAM, DONE.
REQ-018 In IDLE, i_start=1 at an edge SHALL capture i_data and i_mode into internal registers and go to PREP; i_start outside IDLE SHALL be ignored.
REQ-019 PREP SHALL register the first sample (ch 0, idx 0), assert o_valid and go to STREAM, so o_valid rises one cycle after the capture edge.
REQ-020 Output order SHALL be channel-major: for each ch 0..NUM_CHANNELS-1, idx 0..FRAMES_IN*SCALE_FACTOR-1.
REQ-021 For idx = k*SCALE_FACTOR + j, nearest mode SHALL output x[ch][k].
REQ-022 For the same idx, linear mode SHALL output x[k] + ((x[k+1]-x[k])*j) >>> log2(SCALE_FACTOR), using a (DATA_WIDTH+1)-bit difference, a full-width product and arithmetic shift (floor); the result always fits DATA_WIDTH, so no saturation is applied.
REQ-023 Linear mode for k = FRAMES_IN-1 SHALL clamp the edge and output x[FRAMES_IN-1] for every j.
REQ-024 A handshake SHALL be o_valid & i_ready at an edge; only a handshake advances idx/ch and loads the next sample.
REQ-025 While o_valid=1 and i_ready=0, o_data, o_ch and o_idx SHALL hold stable.
REQ-026 With i_ready held at 1, SHALL output one sample per cycle with no bubbles, including across channel boundaries.
REQ-027 The handshake of the last sample SHALL deassert o_valid and enter DONE; DONE SHALL assert o_done_tick for exactly one cycle, then return to IDLE.
REQ-028 i_start may be accepted in the cycle after DONE; captured data SHALL be unaffected by i_data changes after capture.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE and set o_valid, o_busy, o_done_tick = 0, o_data, o_ch, o_idx = 0, and the counters to 0, including mid-job; no o_done_tick is emitted for an aborted job.

Structure
REQ-030 Shared package upsample_pkg SHALL hold the mode enum (UPS_NEAREST, UPS_LINEAR), the state enum, and width helper constants.
REQ-031 Interpolation arithmetic SHALL live in a combinational sub-module upsample_interp_unit (inputs x0, x1, j, mode; output sample).
REQ-032 An elaboration check SHALL fail if SCALE_FACTOR is not a power of 2.

Verification
REQ-033 Nearest, 2ch/2fr/S=2, {111,222},{333,444}, i_ready=1 -> 111,111,222,222,333,333,444,444 on consecutive cycles, then o_done_tick.
REQ-034 Linear, 1ch/2fr/S=4, {0,256} -> 0,64,128,192,256,256,256,256.
REQ-035 Linear, S=2, {-50,60},{60,-80} -> -50,5,60,60 then 60,-10,-80,-80 (floor rounding).
REQ-036 Backpressure: i_ready=0 for 3 cycles at idx 2 -> o_data, o_ch and o_idx hold; no sample is lost or duplicated.
REQ-037 rst pulsed mid-STREAM -> all outputs 0 immediately, no o_done_tick; a next job runs correctly.
REQ-038 i_start during STREAM with new data -> ignored; the stream completes with the original data.
